// File: rtl/game_pkg.sv
// game_pkg: shared launcher states, launch-velocity tables and keyboard codes.
package game_pkg;
   typedef enum logic [1:0] {IDLE, AIM, FLIGHT, DONE} state_t;
   // Element [a] is the per-angle velocity factor; angle 0 is flat and angle 7 is steep.
   localparam logic [7:0][3:0] ANGLE_VX = {4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd8, 4'd8};
   localparam logic [7:0][3:0] ANGLE_VY = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd1, 4'd0};
   localparam logic [7:0] KEY_UP    = 8'd82;
   localparam logic [7:0] KEY_DOWN  = 8'd81;
   localparam logic [7:0] KEY_LEFT  = 8'd54;
   localparam logic [7:0] KEY_RIGHT = 8'd55;
   localparam logic [7:0] KEY_FIRE  = 8'd44;
endpackage

// File: rtl/launch_velocity_lut.sv
// launch_velocity_lut: maps power/angle settings to the initial launch velocity.
// The returned vy is negative, which means upward on screen.
module launch_velocity_lut
   import game_pkg::*;
(
   input  logic        [3:0]  i_power,
   input  logic        [3:0]  i_angle,
   output logic signed [11:0] o_vx,
   output logic signed [11:0] o_vy
);
   logic [3:0] w_p;
   logic [2:0] w_a;
   logic [7:0] w_mx, w_my;
   assign w_p  = (i_power > 4'd7 ? 4'd7 : i_power) + 4'd1;
   assign w_a  = i_angle > 4'd7 ? 3'd7 : i_angle[2:0];
   assign w_mx = {4'd0, w_p} * {4'd0, ANGLE_VX[w_a]};
   assign w_my = {4'd0, w_p} * {4'd0, ANGLE_VY[w_a]};
   assign o_vx = {6'd0, w_mx[7:2]};
   assign o_vy = -{6'd0, w_my[7:2]};
endmodule

// File: rtl/projectile_launcher.sv
// projectile_launcher: fires on a fire-key edge during this player's turn, integrates a
// ballistic flight once per frame and reports where the shot ended.
module projectile_launcher
   import game_pkg::*;
#(
   parameter logic [7:0] FIRE_KEY   = KEY_FIRE,
   parameter bit         DIR_LEFT   = 1'b1,
   parameter int         SCREEN_W   = 640,
   parameter int         GROUND_Y   = 479,
   parameter int         GRAVITY    = 1,
   parameter int         MAX_FLIGHT = 255
)(
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       is_in_turn,
   input  logic [7:0] keycode,
   input  logic [3:0] power,
   input  logic [3:0] angle,
   input  logic [9:0] start_x,
   input  logic [9:0] start_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       ball_active,
   output logic       turn_done,
   output logic [9:0] land_x,
   output logic       landed_ground
);
   localparam logic signed [11:0] X_MAX    = 12'(SCREEN_W - 1);
   localparam logic signed [11:0] Y_GND    = 12'(GROUND_Y);
   localparam logic signed [11:0] G        = 12'(GRAVITY);
   localparam logic signed [11:0] V_MAX    = 12'sd15;
   localparam logic        [7:0]  CNT_LAST = 8'(MAX_FLIGHT - 1);
   state_t             r_state;
   logic               r_key_prev, r_active, r_done, r_lg;
   logic signed [11:0] r_x, r_y, r_vx, r_vy;
   logic        [9:0]  r_land_x;
   logic        [7:0]  r_cnt;
   logic signed [11:0] w_vx0, w_vy0, w_nx, w_ny, w_vy_g;
   logic               w_fire, w_off, w_gnd, w_to;
   launch_velocity_lut u_lut (
      .i_power (power),
      .i_angle (angle),
      .o_vx    (w_vx0),
      .o_vy    (w_vy0)
   );
   assign w_fire = (keycode == FIRE_KEY) && !r_key_prev;
   assign w_nx   = DIR_LEFT ? r_x - r_vx : r_x + r_vx;
   assign w_ny   = r_y + r_vy;
   assign w_vy_g = r_vy + G;
   assign w_off  = w_nx[11] || (w_nx > X_MAX);
   assign w_gnd  = w_ny >= Y_GND;
   assign w_to   = r_cnt == CNT_LAST;
   assign ball_x        = r_x[9:0];
   assign ball_y        = r_y[11] ? 10'd0 : r_y[9:0];
   assign ball_active   = r_active;
   assign turn_done     = r_done;
   assign land_x        = r_land_x;
   assign landed_ground = r_lg;
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         r_state    <= IDLE;
         r_key_prev <= 1'b0;
         r_active   <= 1'b0;
         r_done     <= 1'b0;
         r_lg       <= 1'b0;
         r_x        <= '0;
         r_y        <= '0;
         r_vx       <= '0;
         r_vy       <= '0;
         r_land_x   <= '0;
         r_cnt      <= '0;
      end else begin
         r_key_prev <= keycode == FIRE_KEY;
         r_done     <= 1'b0;
         case (r_state)
            IDLE: begin
               r_active <= 1'b0;
               if (is_in_turn) r_state <= AIM;
            end
            AIM: begin
               if (!is_in_turn) r_state <= IDLE;
               else if (w_fire) begin
                  r_x      <= {2'b00, start_x};
                  r_y      <= {2'b00, start_y};
                  r_vx     <= w_vx0;
                  r_vy     <= w_vy0;
                  r_cnt    <= '0;
                  r_active <= 1'b1;
                  r_state  <= FLIGHT;
               end
            end
            FLIGHT: begin
               r_vy <= w_vy_g > V_MAX ? V_MAX : w_vy_g;
               // Off-screen wins over ground, which wins over the flight timeout.
               if (w_off) begin
                  r_land_x <= w_nx[11] ? 10'd0 : X_MAX[9:0];
                  r_lg     <= 1'b0;
               end else if (w_gnd) begin
                  r_x      <= w_nx;
                  r_y      <= Y_GND;
                  r_land_x <= w_nx[9:0];
                  r_lg     <= 1'b1;
               end else if (w_to) begin
                  r_land_x <= r_x[9:0];
                  r_lg     <= 1'b0;
               end else begin
                  r_x   <= w_nx;
                  r_y   <= w_ny;
                  r_cnt <= r_cnt + 8'd1;
               end
               if (w_off || w_gnd || w_to) begin
                  r_active <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_projectile_launcher.sv
// tb_projectile_launcher: scoreboard bench; each shot's expected per-frame trajectory
// is queued at the fire edge and popped against the launcher outputs frame by frame.
module tb_projectile_launcher;
   logic       frame_clk = 1'b0, Reset = 1'b0, is_in_turn = 1'b0;
   logic [7:0] keycode = 8'd0;
   logic [3:0] power = 4'd0, angle = 4'd0;
   logic [9:0] start_x = 10'd0, start_y = 10'd0;
   logic [9:0] ball_x, ball_y, land_x;
   logic       ball_active, turn_done, landed_ground;
   typedef struct {int x; int y; int act; int done; int lx; int lg;} exp_t;
   exp_t exp_q[$];
   int   n_checks = 0, n_errors = 0;
   int   tvx[8] = '{8, 8, 7, 7, 6, 5, 4, 3};
   int   tvy[8] = '{0, 1, 3, 4, 5, 6, 7, 8};
   always #5 frame_clk = ~frame_clk;
   projectile_launcher dut (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .is_in_turn    (is_in_turn),
      .keycode       (keycode),
      .power         (power),
      .angle         (angle),
      .start_x       (start_x),
      .start_y       (start_y),
      .ball_x        (ball_x),
      .ball_y        (ball_y),
      .ball_active   (ball_active),
      .turn_done     (turn_done),
      .land_x        (land_x),
      .landed_ground (landed_ground)
   );
   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge frame_clk);
      #1;
   endtask
   function automatic int ymax0(input int y);
      return y < 0 ? 0 : y;
   endfunction
   // Reference trajectory for a left-travelling launcher on a 640x480 field.
   task automatic predict(input int sx, input int sy, input int pw, input int an);
      int p, a, vx, vy, x, y, nx, ny, cnt, lx, lg;
      p = (pw > 7 ? 7 : pw) + 1;
      a = an > 7 ? 7 : an;
      vx = p * tvx[a] / 4;
      vy = -(p * tvy[a] / 4);
      x = sx; y = sy; cnt = 0;
      exp_q.push_back('{x, y, 1, 0, 0, 0});
      forever begin
         nx = x - vx;
         ny = y + vy;
         vy = vy + 1 > 15 ? 15 : vy + 1;
         if (nx < 0 || nx > 639) begin
            lx = nx < 0 ? 0 : 639; lg = 0;
            break;
         end
         if (ny >= 479) begin
            x = nx; y = 479; lx = nx; lg = 1;
            break;
         end
         if (cnt == 254) begin
            lx = x; lg = 0;
            break;
         end
         x = nx; y = ny; cnt++;
         exp_q.push_back('{x, ymax0(y), 1, 0, 0, 0});
      end
      exp_q.push_back('{x, ymax0(y), 0, 1, lx, lg});
      exp_q.push_back('{x, ymax0(y), 0, 0, lx, lg});
   endtask
   task automatic arm;
      is_in_turn = 1'b1;
      keycode = 8'd0;
      tick;
      tick;
      check("aim_inactive", ball_active, 0);
   endtask
   task automatic fire(input int sx, input int sy, input int pw, input int an);
      start_x = 10'(sx); start_y = 10'(sy);
      power = 4'(pw); angle = 4'(an);
      keycode = 8'd44;
      predict(sx, sy, pw, an);
   endtask
   task automatic run_shot(input int hold, input int drop_at, input int pchg_at, input int limit);
      exp_t e;
      int f = 0;
      while (exp_q.size() > 0 && f < limit) begin
         e = exp_q.pop_front();
         tick;
         check("ball_x", ball_x, e.x);
         check("ball_y", ball_y, e.y);
         check("ball_active", ball_active, e.act);
         check("turn_done", turn_done, e.done);
         if (e.act == 0) begin
            check("land_x", land_x, e.lx);
            check("landed_ground", landed_ground, e.lg);
         end
         f++;
         if (f >= hold) keycode = 8'd0;
         if (f == drop_at) is_in_turn = 1'b0;
         if (f == pchg_at) begin
            power = 4'd0;
            angle = 4'd0;
         end
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
   initial begin
      tick;
      tick;
      check("rst_ball_x", ball_x, 0);
      check("rst_ball_y", ball_y, 0);
      check("rst_active", ball_active, 0);
      check("rst_done", turn_done, 0);
      check("rst_land_x", land_x, 0);
      check("rst_landed", landed_ground, 0);
      Reset = 1'b1;
      arm;
      fire(500, 400, 3, 7);
      run_shot(1, 0, 0, 1000);
      arm;
      fire(20, 400, 7, 0);
      run_shot(1, 0, 0, 1000);
      // Key held past the end of a short shot, with settings changed mid-flight.
      arm;
      fire(20, 400, 7, 0);
      run_shot(10, 0, 2, 1000);
      repeat (6) begin
         tick;
         check("held_active", ball_active, 0);
         check("held_done", turn_done, 0);
      end
      arm;
      fire(500, 400, 3, 7);
      run_shot(1, 0, 3, 1000);
      is_in_turn = 1'b0;
      keycode = 8'd0;
      tick;
      keycode = 8'd44;
      repeat (4) begin
         tick;
         check("noturn_active", ball_active, 0);
         check("noturn_done", turn_done, 0);
      end
      arm;
      fire(500, 400, 3, 7);
      run_shot(1, 5, 0, 1000);
      arm;
      fire(300, 40, 7, 7);
      run_shot(1, 0, 0, 1000);
      arm;
      fire(500, 400, 3, 7);
      run_shot(1, 0, 0, 4);
      Reset = 1'b0;
      #1;
      check("abort_ball_x", ball_x, 0);
      check("abort_ball_y", ball_y, 0);
      check("abort_active", ball_active, 0);
      check("abort_done", turn_done, 0);
      check("abort_land_x", land_x, 0);
      check("abort_landed", landed_ground, 0);
      exp_q.delete();
      tick;
      Reset = 1'b1;
      is_in_turn = 1'b1;
      keycode = 8'd0;
      repeat (3) begin
         tick;
         check("post_rst_active", ball_active, 0);
         check("post_rst_done", turn_done, 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/projectile_launcher.md
Name: projectile_launcher

Overview:
- Consumes the per-player power/angle registers and fires a projectile when the fire key is pressed during that player's turn.
- Integrates a ballistic trajectory once per frame_clk.
- Drives the ball position to the sprite/colour mapper.
- Pulses turn_done to the turn controller when the shot ends.

Parameters:
FIRE_KEY, 8'd44, keycode that fires (space)
DIR_LEFT, 1, 1 = x decreases during flight (player 2), 0 = x increases (player 1)
SCREEN_W, 640, valid x range 0..SCREEN_W-1
GROUND_Y, 479, y at or beyond which the ball has landed
GRAVITY, 1, added to vy every flight frame
MAX_FLIGHT, 255, flight-frame timeout

Ports:
frame_clk  in  1  frame-rate clock, all state on rising edge
Reset  in  1  asynchronous, active-low reset
is_in_turn  in  1  this player owns the turn
keycode  in  8  current keyboard code
power  in  4  0..7 from power/angle register
angle  in  4  0..7 from power/angle register
start_x  in  10  launch x (tank muzzle)
start_y  in  10  launch y
ball_x  out  10  projectile x
ball_y  out  10  projectile y
ball_active  out  1  projectile visible/in flight
turn_done  out  1  one-frame pulse at end of shot
land_x  out  10  x where shot ended, held until next shot
landed_ground  out  1  1 = hit ground, 0 = off-screen or timeout; held

Behaviour:
- Reset low: state=IDLE; ball_x=0, ball_y=0, ball_active=0, turn_done=0, land_x=0, landed_ground=0; fire edge-detect history=0, vx=0, vy=0, flight counter=0.
- Fire edge: keycode==FIRE_KEY this frame and keycode!=FIRE_KEY the previous frame. History is updated every frame in every state. A held key fires once.
- IDLE: ball_active=0. Go to AIM when is_in_turn=1.
- AIM:
  - is_in_turn=0 returns to IDLE.
  - A fire edge with is_in_turn=1 latches:
    - ball_x=start_x, ball_y=start_y;
    - p=power+1 (values >7 saturate to 7 first);
    - vx=(p*ANGLE_VX[a])>>2 and vy=-((p*ANGLE_VY[a])>>2), where a=angle saturated to 7.
  - Also sets ball_active=1, clears the flight counter and enters FLIGHT on the same edge.
- FLIGHT, every frame:
  - nx = ball_x −/+ vx (DIR_LEFT selects sign); ny = ball_y + vy; vy += GRAVITY, saturating at +15. All computed in signed 12-bit.
  - nx<0 or nx>SCREEN_W-1: land_x=clamp(nx, 0..SCREEN_W-1), landed_ground=0 → DONE.
  - Else ny>=GROUND_Y: ball_x=nx, ball_y=GROUND_Y, land_x=nx, landed_ground=1 → DONE.
  - ny<0 is allowed (ball above screen). ball_y shows 0, the internal y is kept signed, and flight continues.
  - Flight counter reaches MAX_FLIGHT: land_x=ball_x, landed_ground=0 → DONE.
  - Priority: off-screen > ground > timeout.
  - is_in_turn falling during FLIGHT is ignored; the shot is committed.
- DONE: lasts one frame. turn_done=1 and ball_active=0 during this frame, then IDLE. land_x and landed_ground hold until the next fire.
- turn_done is registered; it is high exactly one frame per shot.
- Reset asserted mid-flight aborts the shot with no turn_done.
- power/angle changes after the fire edge do not affect the trajectory.

Decomposition:
- Shared package game_pkg holds:
  - the state enum {IDLE, AIM, FLIGHT, DONE};
  - ANGLE_VX = {8,8,7,7,6,5,4,3};
  - ANGLE_VY = {0,1,3,4,5,6,7,8};
  - the keycode constants (UP 82, DOWN 81, LEFT 54, RIGHT 55, FIRE 44).
- One sub-module, launch_velocity_lut: combinational map (power, angle) → (vx, vy). It is shared with player 1's launcher.

Test Plan:
- Reset low mid-FLIGHT → all outputs 0 immediately, state IDLE; release, is_in_turn=1, no key → stays AIM, ball_active=0.
- DIR_LEFT=1, start=(500,400), power=3, angle=7, fire edge → frame1 ball=(500,400) vx=3 vy=-8; frame2 (497,392); frame3 (494,385); vy=-6 afterwards; ball_active=1 throughout.
- Same shot continued → ball reaches y>=479, ball_y=479, landed_ground=1, land_x equals the final x; turn_done high exactly one frame; ball_active=0 next frame.
- start=(20,400), power=7, angle=0 (vx=16, vy=0) → x 20→4, next nx=-12 → land_x=0, landed_ground=0, turn_done pulse.
- FIRE key held 10 frames, then power changed to 0 mid-flight → exactly one launch; velocity unchanged; only one turn_done.
- is_in_turn=0 with fire edge → no launch; is_in_turn dropped during FLIGHT → flight completes and turn_done still pulses.
